// File: rtl/picomips_pkg.sv
// picomips_pkg: shared constants and types for the picoMIPS core.
//   ADDR_W / DATA_W : instruction address and instruction widths
//   instr_t         : one 16-bit instruction word
//   iaddr_t         : 6-bit instruction address (program counter width)
//   NOP             : all-zero instruction
//   DEFAULT_PROG    : boot image loaded into program memory on reset
package picomips_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  typedef logic [15:0] instr_t;
  typedef logic [5:0]  iaddr_t;

  localparam instr_t NOP = 16'h0000;

  // Four arithmetic instructions, then an unconditional branch back to 0.
  // Everything above the loop is NOP.
  localparam instr_t DEFAULT_PROG [0:63] = '{
    0:       16'h1040,
    1:       16'h2081,
    2:       16'h30C2,
    3:       16'h4103,
    4:       16'hF000,
    default: NOP
  };

endpackage

// File: rtl/picomips_program_memory.sv
// picomips_program_memory: 64 x 16 instruction store for the picoMIPS core.
// Sits between the PC register and the instruction decoder.
//
// Ports:
//   clk         in   load-port writes are captured on the rising edge
//   reset       in   asynchronous, active-low; restores DEFAULT_PROG
//   address     in   fetch address from the PC
//   instruction out  mem[address], purely combinational
//   wr_en       in   load-port write enable, active-high
//   wr_addr     in   load-port word address
//   wr_data     in   load-port write data
//
// Load port: a single-cycle strobe. A word is written on each rising clk
// edge where wr_en = 1 and reset = 1; there is no ready/backpressure, the
// memory always accepts. Writes seen while reset = 0 are discarded.
// The read path has no bypass: a write to the word currently being fetched
// shows up on instruction only after the capturing edge.
module picomips_program_memory
  import picomips_pkg::*;
#(
  parameter int ADDR_W = picomips_pkg::ADDR_W,
  parameter int DATA_W = picomips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset has priority: while reset is low every word is forced to the
  // boot image, so a write strobe in that window has no effect, including
  // on the edge that coincides with reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(DEFAULT_PROG[i]);
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign instruction = mem[address];

endmodule

// File: tb/tb_picomips_program_memory.sv
// tb_picomips_program_memory: directed scenarios plus a randomized run,
// all checked against a word-array model of the program memory.
module tb_picomips_program_memory;

  logic        clk;
  logic        reset;
  logic [5:0]  address;
  logic [15:0] instruction;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;

  int checks;
  int errors;

  // Reference model: what each word should hold.
  logic [15:0] model [64];

  picomips_program_memory dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .instruction (instruction),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [15:0] boot_word(input int a);
    case (a)
      0:       return 16'h1040;
      1:       return 16'h2081;
      2:       return 16'h30C2;
      3:       return 16'h4103;
      4:       return 16'hF000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = boot_word(i);
  endtask

  // ---------------- driver tasks ----------------
  // One load-port write: drive at negedge, capture at posedge.
  task automatic drive_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (reset) model[a] = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    // Start released, then drop reset so a clean negedge loads the image.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    for (int a = 0; a < 5; a++) begin
      address = 6'(a);
      #10;
      checks++;
      if (instruction !== boot_word(a)) begin
        errors++;
        $display("FAIL reset_read addr=%0d: got %h expected %h", a, instruction, boot_word(a));
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_upper_range();
    logic [5:0] addrs [3];
    addrs = '{6'd5, 6'd37, 6'd63};
    for (int i = 0; i < 3; i++) begin
      address = addrs[i];
      #1;
      checks++;
      if (instruction !== 16'h0000) begin
        errors++;
        $display("FAIL upper_range addr=%0d: got %h expected 0000", addrs[i], instruction);
      end
    end
  endtask

  task automatic test_load_readback();
    logic [5:0]  addrs [4];
    logic [15:0] exp   [4];
    drive_write(6'd10, 16'hABCD);
    drive_write(6'd63, 16'h1234);
    addrs = '{6'd10, 6'd63, 6'd9, 6'd11};
    exp   = '{16'hABCD, 16'h1234, 16'h0000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      address = addrs[i];
      #1;
      checks++;
      if (instruction !== exp[i] || instruction !== model[addrs[i]]) begin
        errors++;
        $display("FAIL load_readback addr=%0d: got %h expected %h", addrs[i], instruction, exp[i]);
      end
    end
  endtask

  task automatic test_write_blocked();
    @(negedge clk);
    reset   = 1'b0;
    model_reset();
    wr_en   = 1'b1;
    wr_addr = 6'd2;
    wr_data = 16'hFFFF;
    address = 6'd2;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (instruction !== 16'h30C2) begin
        errors++;
        $display("FAIL write_blocked: got %h expected 30c2", instruction);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (instruction !== 16'h30C2) begin
      errors++;
      $display("FAIL write_blocked_after_release: got %h expected 30c2", instruction);
    end
  endtask

  task automatic test_reset_mid_op();
    drive_write(6'd0, 16'h5555);
    drive_write(6'd20, 16'h7777);
    address = 6'd0;
    #1;
    checks++;
    if (instruction !== 16'h5555) begin
      errors++;
      $display("FAIL mid_op_loaded: got %h expected 5555", instruction);
    end
    // Pulse reset strictly between edges.
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (instruction !== 16'h1040) begin
      errors++;
      $display("FAIL mid_op_reset addr0: got %h expected 1040", instruction);
    end
    address = 6'd20;
    #1;
    checks++;
    if (instruction !== 16'h0000) begin
      errors++;
      $display("FAIL mid_op_reset addr20: got %h expected 0000", instruction);
    end
    reset = 1'b1;
    // Words loaded earlier must also be back to the image.
    address = 6'd10;
    #1;
    checks++;
    if (instruction !== model[10]) begin
      errors++;
      $display("FAIL mid_op_reset addr10: got %h expected %h", instruction, model[10]);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    address = 6'd3;
    wr_addr = 6'd3;
    wr_data = 16'h0F0F;
    wr_en   = 1'b1;
    #1;
    checks++;
    if (instruction !== 16'h4103) begin
      errors++;
      $display("FAIL rdw_before: got %h expected 4103", instruction);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[3] = 16'h0F0F;
    checks++;
    if (instruction !== 16'h0F0F) begin
      errors++;
      $display("FAIL rdw_after: got %h expected 0f0f", instruction);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        // Occasional reset pulse between edges.
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
      end
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 6'($urandom_range(0, 63));
      wr_data = 16'($urandom);
      address = 6'($urandom_range(0, 63));
      #1;
      checks++;
      if (instruction !== model[address]) begin
        errors++;
        $display("FAIL random_pre n=%0d addr=%0d: got %h expected %h", n, address, instruction, model[address]);
      end
      @(posedge clk);
      if (wr_en && reset) model[wr_addr] = wr_data;
      #1;
      checks++;
      if (instruction !== model[address]) begin
        errors++;
        $display("FAIL random_post n=%0d addr=%0d: got %h expected %h", n, address, instruction, model[address]);
      end
    end
    wr_en = 1'b0;
    // Sweep the whole array once against the model.
    for (int a = 0; a < 64; a++) begin
      address = 6'(a);
      #1;
      checks++;
      if (instruction !== model[a]) begin
        errors++;
        $display("FAIL random_sweep addr=%0d: got %h expected %h", a, instruction, model[a]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    address = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 64; i++) model[i] = 16'h0000;

    test_reset();
    test_upper_range();
    test_load_readback();
    test_write_blocked();
    test_reset_mid_op();
    test_read_during_write();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
